// File: rtl/ddr_cmd_sequencer.sv
// ddr_cmd_sequencer: DDR4 command/address pin driver issuing PRE/ACT/CAS for one RD/WR request at a time
// Optional feature: define AUTO_PRECHARGE_EN for RDA/WRA (closed-page) operation; default is open-page.
// Ports:
//   CK_t, reset_n                  clock (posedge), asynchronous active-low reset
//   req_valid/req_ready            request handshake (accept = valid && ready)
//   req_wr, req_bl8                1=write/0=read, 1=BL8/0=BC4
//   req_bg, req_ba, req_row, req_col   target bank group, bank, row, column
//   cs_n, act_n, RAS_n_A16, CAS_n_A15, WE_n_A14   command pins
//   bg_addr, ba_addr, A13, A12_BC_n, A11, A10_AP, A9_A0   address pins (hold when deselected)
//   no_act_rdy                     pulse: accepted request hit the open row
//   rd_rdy                         pulse: RD command is on the pins this cycle
module ddr_cmd_sequencer #(
    parameter int TRP  = 4,
    parameter int TRCD = 4,
    parameter int TCCD = 4
) (
    input  logic        CK_t,
    input  logic        reset_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_wr,
    input  logic        req_bl8,
    input  logic [1:0]  req_bg,
    input  logic [1:0]  req_ba,
    input  logic [13:0] req_row,
    input  logic [9:0]  req_col,
    output logic        cs_n,
    output logic        act_n,
    output logic        RAS_n_A16,
    output logic        CAS_n_A15,
    output logic        WE_n_A14,
    output logic [1:0]  bg_addr,
    output logic [1:0]  ba_addr,
    output logic        A13,
    output logic        A12_BC_n,
    output logic        A11,
    output logic        A10_AP,
    output logic [9:0]  A9_A0,
    output logic        no_act_rdy,
    output logic        rd_rdy
);
    localparam int TMAX = (TRP > TRCD) ? ((TRP > TCCD) ? TRP : TCCD) : ((TRCD > TCCD) ? TRCD : TCCD);
    localparam int CW = $clog2(TMAX + 1);
    localparam logic [CW-1:0] L_RP  = CW'(TRP - 1);
    localparam logic [CW-1:0] L_RCD = CW'(TRCD - 1);
    localparam logic [CW-1:0] L_CCD = CW'(TCCD - 1);
    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_PRE  = 3'd1;
    localparam logic [2:0] S_WRP  = 3'd2;
    localparam logic [2:0] S_ACT  = 3'd3;
    localparam logic [2:0] S_WRCD = 3'd4;
    localparam logic [2:0] S_CAS  = 3'd5;
    localparam logic [2:0] S_WCCD = 3'd6;

    logic [2:0]    r_state;
    logic [CW-1:0] r_cnt;
    logic [15:0]   r_open;
    logic [13:0]   r_rows [16];
    logic          r_wr;
    logic          r_bl8;
    logic [3:0]    r_bank;
    logic [13:0]   r_row;
    logic [9:0]    r_col;

    logic [3:0] w_idx;
    logic       w_accept;
    logic       w_hit;
    assign w_idx    = {req_bg, req_ba};
    assign w_accept = req_valid && req_ready;
    assign w_hit    = r_open[w_idx] && (r_rows[w_idx] == req_row);

    always_ff @(posedge CK_t or negedge reset_n) begin
        if (!reset_n) begin
            r_state    <= S_IDLE;
            r_cnt      <= '0;
            r_open     <= '0;
            for (int i = 0; i < 16; i++) r_rows[i] <= '0;
            r_wr       <= 1'b0;
            r_bl8      <= 1'b0;
            r_bank     <= '0;
            r_row      <= '0;
            r_col      <= '0;
            req_ready  <= 1'b0;
            cs_n       <= 1'b1;
            act_n      <= 1'b1;
            RAS_n_A16  <= 1'b1;
            CAS_n_A15  <= 1'b1;
            WE_n_A14   <= 1'b1;
            bg_addr    <= '0;
            ba_addr    <= '0;
            A13        <= 1'b0;
            A12_BC_n   <= 1'b0;
            A11        <= 1'b0;
            A10_AP     <= 1'b0;
            A9_A0      <= '0;
            no_act_rdy <= 1'b0;
            rd_rdy     <= 1'b0;
        end else begin
            // deselect by default; address pins keep their last value
            cs_n       <= 1'b1;
            act_n      <= 1'b1;
            RAS_n_A16  <= 1'b1;
            CAS_n_A15  <= 1'b1;
            WE_n_A14   <= 1'b1;
            no_act_rdy <= 1'b0;
            rd_rdy     <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    req_ready <= !w_accept;
                    if (w_accept) begin
                        r_wr       <= req_wr;
                        r_bl8      <= req_bl8;
                        r_bank     <= w_idx;
                        r_row      <= req_row;
                        r_col      <= req_col;
                        no_act_rdy <= w_hit;
                        r_state    <= w_hit ? S_CAS : (r_open[w_idx] ? S_PRE : S_ACT);
                    end
                end
                S_PRE: begin
                    cs_n           <= 1'b0;
                    RAS_n_A16      <= 1'b0;
                    WE_n_A14       <= 1'b0;
                    {bg_addr, ba_addr} <= r_bank;
                    A10_AP         <= 1'b0;
                    r_open[r_bank] <= 1'b0;
                    r_cnt          <= L_RP;
                    r_state        <= (TRP > 1) ? S_WRP : S_ACT;
                end
                S_WRP: begin
                    r_cnt <= r_cnt - CW'(1);
                    if (r_cnt == CW'(1)) r_state <= S_ACT;
                end
                S_ACT: begin
                    cs_n           <= 1'b0;
                    act_n          <= 1'b0;
                    RAS_n_A16      <= 1'b0;
                    CAS_n_A15      <= 1'b0;
                    WE_n_A14       <= 1'b0;
                    {bg_addr, ba_addr} <= r_bank;
                    {A13, A12_BC_n, A11, A10_AP, A9_A0} <= r_row;
                    r_open[r_bank] <= 1'b1;
                    r_rows[r_bank] <= r_row;
                    r_cnt          <= L_RCD;
                    r_state        <= (TRCD > 1) ? S_WRCD : S_CAS;
                end
                S_WRCD: begin
                    r_cnt <= r_cnt - CW'(1);
                    if (r_cnt == CW'(1)) r_state <= S_CAS;
                end
                S_CAS: begin
                    cs_n      <= 1'b0;
                    CAS_n_A15 <= 1'b0;
                    WE_n_A14  <= !r_wr;
                    rd_rdy    <= !r_wr;
                    {bg_addr, ba_addr} <= r_bank;
                    A13       <= 1'b0;
                    A12_BC_n  <= r_bl8;
                    A11       <= 1'b0;
                    A9_A0     <= r_col;
`ifdef AUTO_PRECHARGE_EN
                    A10_AP         <= 1'b1;
                    r_open[r_bank] <= 1'b0;
`else
                    A10_AP    <= 1'b0;
`endif
                    r_cnt     <= L_CCD;
                    req_ready <= (TCCD == 1);
                    r_state   <= (TCCD > 1) ? S_WCCD : S_IDLE;
                end
                S_WCCD: begin
                    r_cnt <= r_cnt - CW'(1);
                    if (r_cnt == CW'(1)) begin
                        r_state   <= S_IDLE;
                        req_ready <= 1'b1;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_ddr_cmd_sequencer.sv
// tb_ddr_cmd_sequencer: directed self-checking bench for ddr_cmd_sequencer (TRP=TRCD=TCCD=4)
module tb_ddr_cmd_sequencer;
    localparam int TRP  = 4;
    localparam int TRCD = 4;
    localparam int TCCD = 4;
`ifdef AUTO_PRECHARGE_EN
    localparam bit AP = 1'b1;
`else
    localparam bit AP = 1'b0;
`endif
    localparam int HIT = 0, CLOSED = 1, CONFLICT = 2;

    logic        CK_t = 1'b0;
    logic        reset_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_wr = 1'b0;
    logic        req_bl8 = 1'b0;
    logic [1:0]  req_bg = '0;
    logic [1:0]  req_ba = '0;
    logic [13:0] req_row = '0;
    logic [9:0]  req_col = '0;
    logic        req_ready, cs_n, act_n, RAS_n_A16, CAS_n_A15, WE_n_A14;
    logic [1:0]  bg_addr, ba_addr;
    logic        A13, A12_BC_n, A11, A10_AP;
    logic [9:0]  A9_A0;
    logic        no_act_rdy, rd_rdy;
    logic [4:0]  cmd;
    logic [13:0] addr14;
    int checks = 0;
    int errors = 0;

    assign cmd    = {cs_n, act_n, RAS_n_A16, CAS_n_A15, WE_n_A14};
    assign addr14 = {A13, A12_BC_n, A11, A10_AP, A9_A0};

    always #5 CK_t = ~CK_t;

    ddr_cmd_sequencer #(.TRP(TRP), .TRCD(TRCD), .TCCD(TCCD)) dut (
        .CK_t(CK_t), .reset_n(reset_n), .req_valid(req_valid), .req_ready(req_ready),
        .req_wr(req_wr), .req_bl8(req_bl8), .req_bg(req_bg), .req_ba(req_ba),
        .req_row(req_row), .req_col(req_col), .cs_n(cs_n), .act_n(act_n),
        .RAS_n_A16(RAS_n_A16), .CAS_n_A15(CAS_n_A15), .WE_n_A14(WE_n_A14),
        .bg_addr(bg_addr), .ba_addr(ba_addr), .A13(A13), .A12_BC_n(A12_BC_n),
        .A11(A11), .A10_AP(A10_AP), .A9_A0(A9_A0), .no_act_rdy(no_act_rdy), .rd_rdy(rd_rdy)
    );

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic wait_ready();
        int n;
        n = 0;
        while (!req_ready && n < 50) begin
            @(negedge CK_t);
            n++;
        end
        chk("ready_wait", 32'(req_ready), 32'd1);
    endtask

    // kind0 is the open-page expectation; auto-precharge turns every access into the closed path
    task automatic access(input logic wr, input logic bl8, input logic [1:0] bg, input logic [1:0] ba,
                          input logic [13:0] row, input logic [9:0] col, input int kind0);
        int kind, t_pre, t_act, t_cas;
        kind  = AP ? CLOSED : kind0;
        t_pre = (kind == CONFLICT) ? 1 : -1;
        t_act = (kind == CONFLICT) ? 1 + TRP : (kind == CLOSED) ? 1 : -1;
        t_cas = (kind == CONFLICT) ? 1 + TRP + TRCD : (kind == CLOSED) ? 1 + TRCD : 1;
        wait_ready();
        req_valid = 1'b1; req_wr = wr; req_bl8 = bl8; req_bg = bg; req_ba = ba;
        req_row = row; req_col = col;
        @(negedge CK_t);
        req_valid = 1'b0; req_wr = ~wr; req_bl8 = ~bl8; req_bg = ~bg; req_ba = ~ba;
        req_row = ~row; req_col = ~col;
        chk("acc_ready", 32'(req_ready), 32'd0);
        chk("no_act_rdy", 32'(no_act_rdy), 32'(kind == HIT));
        chk("acc_cmd", 32'(cmd), 32'h1f);
        for (int k = 1; k <= t_cas + TCCD - 1; k++) begin
            @(negedge CK_t);
            chk("rd_rdy", 32'(rd_rdy), 32'(k == t_cas && !wr));
            chk("no_act_idle", 32'(no_act_rdy), 32'd0);
            chk("ready", 32'(req_ready), 32'(k == t_cas + TCCD - 1));
            if (k == t_pre) begin
                chk("pre_cmd", 32'(cmd), 32'b01010);
                chk("pre_bank", 32'({bg_addr, ba_addr}), 32'({bg, ba}));
                chk("pre_a10", 32'(A10_AP), 32'd0);
            end else if (k == t_act) begin
                chk("act_cmd", 32'(cmd), 32'b00000);
                chk("act_bank", 32'({bg_addr, ba_addr}), 32'({bg, ba}));
                chk("act_row", 32'(addr14), 32'(row));
            end else if (k == t_cas) begin
                chk("cas_cmd", 32'(cmd), 32'({4'b0110, !wr}));
                chk("cas_bank", 32'({bg_addr, ba_addr}), 32'({bg, ba}));
                chk("cas_col", 32'(A9_A0), 32'(col));
                chk("cas_bc", 32'(A12_BC_n), 32'(bl8));
                chk("cas_a13_a11", 32'({A13, A11}), 32'd0);
                chk("cas_ap", 32'(A10_AP), 32'(AP));
            end else begin
                chk("deselect", 32'(cmd), 32'h1f);
            end
        end
        chk("hold_col", 32'(A9_A0), 32'(col));
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        repeat (3) @(negedge CK_t);
        chk("rst_cmd", 32'(cmd), 32'h1f);
        chk("rst_addr", 32'({bg_addr, ba_addr, addr14}), 32'd0);
        chk("rst_ready", 32'(req_ready), 32'd0);
        chk("rst_pulses", 32'({no_act_rdy, rd_rdy}), 32'd0);
        reset_n = 1'b1;
        @(negedge CK_t);
        chk("rel_ready", 32'(req_ready), 32'd1);
        access(1'b0, 1'b1, 2'd1, 2'd2, 14'h0123, 10'h040, CLOSED);
        access(1'b1, 1'b0, 2'd1, 2'd2, 14'h0123, 10'h155, HIT);
        access(1'b0, 1'b1, 2'd1, 2'd2, 14'h0200, 10'h3ff, CONFLICT);
        access(1'b1, 1'b1, 2'd0, 2'd0, 14'h0aaa, 10'h001, CLOSED);
        access(1'b0, 1'b0, 2'd3, 2'd3, 14'h1555, 10'h2aa, CLOSED);
        access(1'b0, 1'b1, 2'd0, 2'd0, 14'h0aaa, 10'h002, HIT);
        access(1'b1, 1'b0, 2'd3, 2'd3, 14'h1555, 10'h003, HIT);
        wait_ready();
        req_valid = 1'b1; req_wr = 1'b0; req_bl8 = 1'b1; req_bg = 2'd2; req_ba = 2'd1;
        req_row = 14'h3fff; req_col = 10'h010;
        @(negedge CK_t);
        req_valid = 1'b0;
        @(negedge CK_t);
        chk("abort_act", 32'(cmd), 32'b00000);
        @(negedge CK_t);
        reset_n = 1'b0;
        #1;
        chk("abort_cmd", 32'(cmd), 32'h1f);
        chk("abort_ready", 32'(req_ready), 32'd0);
        chk("abort_addr", 32'({bg_addr, ba_addr, addr14}), 32'd0);
        @(negedge CK_t);
        reset_n = 1'b1;
        @(negedge CK_t);
        chk("abort_rel_ready", 32'(req_ready), 32'd1);
        access(1'b0, 1'b1, 2'd2, 2'd1, 14'h3fff, 10'h010, CLOSED);
        access(1'b0, 1'b0, 2'd1, 2'd2, 14'h0200, 10'h000, CLOSED);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
